// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for a single register-file write port.
// RFWA_ROUND_ROBIN_EN selects round-robin; default is fixed A-over-B.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_wEn,
    output logic [ADDR_W-1:0] rf_adr3,
    output logic [DATA_W-1:0] rf_word,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_pending,
    output logic [15:0]       wr_count
);

    logic              r_a_vld;
    logic [ADDR_W-1:0] r_a_addr;
    logic [DATA_W-1:0] r_a_data;
    logic              r_b_vld;
    logic [ADDR_W-1:0] r_b_addr;
    logic [DATA_W-1:0] r_b_data;
    logic [15:0]       r_cnt;

    logic w_gnt_a;
    logic w_gnt_b;
    logic w_acc_a;
    logic w_acc_b;
    logic w_hit_a;
    logic w_hit_b;

`ifdef RFWA_ROUND_ROBIN_EN
    // 0 points at A, 1 points at B
    logic r_ptr;

    assign w_gnt_a = r_a_vld & (~r_b_vld | ~r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_gnt_a) begin
            r_ptr <= 1'b1;
        end else if (w_gnt_b) begin
            r_ptr <= 1'b0;
        end
    end
`else
    assign w_gnt_a = r_a_vld;
`endif

    assign w_gnt_b = r_b_vld & ~w_gnt_a;

    assign a_ready = rst_n & (~r_a_vld | w_gnt_a);
    assign b_ready = rst_n & (~r_b_vld | w_gnt_b);
    assign w_acc_a = a_valid & a_ready;
    assign w_acc_b = b_valid & b_ready;

    assign rf_wEn  = w_gnt_a | w_gnt_b;
    assign rf_adr3 = w_gnt_a ? r_a_addr :
                     w_gnt_b ? r_b_addr : '0;
    assign rf_word = w_gnt_a ? r_a_data :
                     w_gnt_b ? r_b_data : '0;

    assign w_hit_a   = r_a_vld & (r_a_addr == q_addr);
    assign w_hit_b   = r_b_vld & (r_b_addr == q_addr);
    assign q_pending = (q_addr != '0) & (w_hit_a | w_hit_b);

    assign wr_count = r_cnt;

    // Writes to x0 are dropped at acceptance so they never reach the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_vld  <= 1'b0;
            r_a_addr <= '0;
            r_a_data <= '0;
        end else if (w_acc_a && (a_addr != '0)) begin
            r_a_vld  <= 1'b1;
            r_a_addr <= a_addr;
            r_a_data <= a_data;
        end else if (w_gnt_a) begin
            r_a_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_vld  <= 1'b0;
            r_b_addr <= '0;
            r_b_data <= '0;
        end else if (w_acc_b && (b_addr != '0)) begin
            r_b_vld  <= 1'b1;
            r_b_addr <= b_addr;
            r_b_data <= b_data;
        end else if (w_gnt_b) begin
            r_b_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (rf_wEn && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and random checks of regfile_wr_arbiter against a
// slot-level reference model; follows RFWA_ROUND_ROBIN_EN if defined.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        rf_wEn;
    logic [4:0]  rf_adr3;
    logic [31:0] rf_word;
    logic [4:0]  q_addr = '0;
    logic        q_pending;
    logic [15:0] wr_count;

    int n_pass = 0;
    int n_total = 0;

    regfile_wr_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .rf_wEn   (rf_wEn),
        .rf_adr3  (rf_adr3),
        .rf_word  (rf_word),
        .q_addr   (q_addr),
        .q_pending(q_pending),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Pending writes per requester; last_win: 0 none, 1 A, 2 B
    bit          m_pa;
    bit [4:0]    m_aa;
    bit [31:0]   m_ad;
    bit          m_pb;
    bit [4:0]    m_ba;
    bit [31:0]   m_bd;
    int          m_last;
    int unsigned m_writes;
    int          n_b7;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_pa = 0;
        m_pb = 0;
        m_aa = '0;
        m_ba = '0;
        m_ad = '0;
        m_bd = '0;
        m_last = 2;
        m_writes = 0;
    endtask

    task automatic cyc(input logic av, input logic [4:0] aa,
                       input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba,
                       input logic [31:0] bd,
                       input logic [4:0] q);
        int    w;
        bit    ar;
        bit    br;
        bit    qp;
        bit [15:0] cnt;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        q_addr = q;
        #1;
        w = 0;
        if (m_pa && m_pb) begin
`ifdef RFWA_ROUND_ROBIN_EN
            w = (m_last == 1) ? 2 : 1;
`else
            w = 1;
`endif
        end else if (m_pa) begin
            w = 1;
        end else if (m_pb) begin
            w = 2;
        end
        ar = !m_pa || (w == 1);
        br = !m_pb || (w == 2);
        qp = (q != 0) && ((m_pa && m_aa == q) ||
                          (m_pb && m_ba == q));
        cnt = (m_writes > 16'hFFFF) ? 16'hFFFF : m_writes[15:0];
        chk("a_ready", a_ready, ar);
        chk("b_ready", b_ready, br);
        chk("rf_wEn", rf_wEn, w != 0);
        chk("rf_adr3", rf_adr3,
            (w == 1) ? m_aa : (w == 2) ? m_ba : 0);
        chk("rf_word", rf_word,
            (w == 1) ? m_ad : (w == 2) ? m_bd : 0);
        chk("q_pending", q_pending, qp);
        chk("wr_count", wr_count, cnt);
        if (rf_wEn && rf_adr3 == 5'd7) n_b7++;
        @(posedge clk);
        if (w != 0) begin
            m_writes++;
            m_last = w;
        end
        if (w == 1) m_pa = 0;
        if (w == 2) m_pb = 0;
        if (av && ar && aa != 0) begin
            m_pa = 1; m_aa = aa; m_ad = ad;
        end
        if (bv && br && ba != 0) begin
            m_pb = 1; m_ba = ba; m_bd = bd;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_wEn"}, rf_wEn, 0);
        chk({tag, "_ar"}, a_ready, 0);
        chk({tag, "_br"}, b_ready, 0);
        chk({tag, "_qp"}, q_pending, 0);
        chk({tag, "_cnt"}, wr_count, 0);
    endtask

    initial begin
        bit [15:0] saved;
        mreset();
        n_b7 = 0;
        #1;
        chk_rst("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single A write
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 5);
        chk("single_cnt", wr_count, 1);
        idle(1);

        // x0 writes are dropped
        saved = wr_count;
        cyc(1, 0, 32'h1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("a0_cnt", wr_count, saved);
        chk("a0_ready", a_ready, 1);

        // contention, then back-to-back repeat
        cyc(1, 3, 32'hA3, 1, 4, 32'hB4, 3);
        cyc(1, 3, 32'hA33, 1, 4, 32'hB44, 4);
        idle(4);

        // A streams while B holds addr 7 / addr 9
        for (int i = 0; i < 6; i++)
            cyc(1, 5'(10 + i), i, 1, 7, 32'h77, 7);
        idle(3);
`ifndef RFWA_ROUND_ROBIN_EN
        chk("b7_starved", n_b7, 1);
`endif
        cyc(1, 2, 32'h22, 1, 9, 32'h99, 9);
        for (int i = 0; i < 3; i++)
            cyc(1, 5'(20 + i), i, 0, 0, 0, 9);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 31)), $urandom,
                5'($urandom_range(0, 31)));
        end

        // reset with both buffers loaded
        idle(2);
        cyc(1, 6, 32'h66, 1, 8, 32'h88, 0);
        a_valid = 0;
        b_valid = 0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_rst("rstmid");
        mreset();
        @(negedge clk);
        chk_rst("rsthold");
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_cnt", wr_count, 0);
        cyc(1, 12, 32'hC, 0, 0, 0, 12);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of write data.
REQ-002 SHALL have parameter ADDR_W, default 5, width of register address.
REQ-003 SHALL have port clk input 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n input 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports a_valid input 1, a_ready output 1, a_addr input ADDR_W, a_data input DATA_W; requester A (ALU writeback).
REQ-006 SHALL have ports b_valid input 1, b_ready output 1, b_addr input ADDR_W, b_data input DATA_W; requester B (load writeback).
REQ-007 SHALL have ports rf_wEn output 1, rf_adr3 output ADDR_W, rf_word output DATA_W; drive the register file's single write port.
REQ-008 SHALL have ports q_addr input ADDR_W, q_pending output 1; hazard query for decode stall.
REQ-009 SHALL have port wr_count output 16, saturating count of register-file writes issued.

Function
REQ-010 SHALL accept a requester transfer on a rising edge where valid and ready are both 1.
REQ-011 SHALL hold one buffer entry per requester (valid bit, addr, data), loaded on acceptance.
REQ-012 SHALL drive ready = buffer empty OR buffer granted this cycle, allowing back-to-back acceptance.
REQ-013 SHALL discard an accepted request with addr 0: buffer not loaded, never drives rf_wEn, not counted.
REQ-014 SHALL select one winner per cycle among valid buffers; single valid buffer always wins.
REQ-015 SHALL drive rf_wEn=1, rf_adr3, rf_word combinationally from the winning buffer; rf_wEn=0 with rf_adr3=0, rf_word=0 when no buffer valid.
REQ-016 SHALL clear the winner's buffer valid at the rising edge of the grant cycle unless reloaded by a simultaneous acceptance.
REQ-017 SHALL provide latency 1: request accepted at edge N appears on rf_wEn in cycle N..N+1 if uncontended; register file writes at edge N+1.
REQ-018 SHALL delay the loser by exactly one cycle per contention; neither requester waits more than one grant when RR enabled.
REQ-019 SHALL, when both buffers target the same address, issue both writes in arbitration order; last write wins in register file.
REQ-020 SHALL assert q_pending when q_addr != 0 and any valid buffer addr equals q_addr; combinational.
REQ-021 SHALL increment wr_count on every cycle with rf_wEn=1, saturating at 16'hFFFF.

Reset
REQ-022 SHALL on rst_n=0 immediately clear both buffer valids, priority pointer to A, wr_count to 0.
REQ-023 SHALL hold a_ready=b_ready=0, rf_wEn=0, q_pending=0 while rst_n=0.
REQ-024 SHALL drop buffered writes when reset asserts mid-operation; no partial write issued after release.
REQ-025 SHALL resume acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro RFWA_ROUND_ROBIN_EN to select arbitration policy.
REQ-027 SHALL, with RFWA_ROUND_ROBIN_EN defined, keep a 1-bit priority pointer: on contention the pointed requester wins; after any grant, pointer moves to the non-granted requester.
REQ-028 SHALL, without RFWA_ROUND_ROBIN_EN, use fixed priority A over B; B may starve under continuous A traffic; no pointer flop exists.

Verification
REQ-029 SHALL test single A: a_addr=5, a_data=32'hDEADBEEF accepted -> next cycle rf_wEn=1, rf_adr3=5, rf_word=32'hDEADBEEF, wr_count=1.
REQ-030 SHALL test contention (RR): A addr 3 and B addr 4 accepted same edge -> A written first, B next cycle; repeat -> B first.
REQ-031 SHALL test fixed priority (no macro): A valid every cycle, B addr 7 buffered -> b_ready stays 0, no write to 7 while A streams.
REQ-032 SHALL test addr 0: a_addr=0, a_data=32'h1 -> rf_wEn stays 0, wr_count unchanged, a_ready remains 1.
REQ-033 SHALL test hazard: B buffered addr 9 stalled by A, q_addr=9 -> q_pending=1 until B grant edge, then 0.
REQ-034 SHALL test reset mid-operation: both buffers valid, rst_n pulsed low -> rf_wEn=0 immediately, wr_count=0, no writes after release.
